// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: pre-add/multiply/post-add MAC slice with valid pipe, stall and accumulation window flag (DSP_SAT_EN: saturating P)
module dsp_mac_slice #(
   parameter int A_WIDTH = 18,
   parameter int B_WIDTH = 18,
   parameter int C_WIDTH = 48,
   parameter int P_WIDTH = 48,
   parameter int MREG    = 1,
   parameter int ACC_LEN = 0
) (
   input  logic               clk,
   input  logic               RST,
   input  logic               CE,
   input  logic               in_valid,
   input  logic [A_WIDTH-1:0] A,
   input  logic [B_WIDTH-1:0] B,
   input  logic [B_WIDTH-1:0] D,
   input  logic [C_WIDTH-1:0] C,
   input  logic [P_WIDTH-1:0] PCIN,
   input  logic               CARRYIN,
   input  logic [7:0]         OPMODE,
   output logic [P_WIDTH-1:0] P,
   output logic [P_WIDTH-1:0] PCOUT,
   output logic [B_WIDTH-1:0] BCOUT,
   output logic               CARRYOUT,
   output logic               out_valid,
   output logic               out_last
);
   localparam int M_WIDTH = A_WIDTH + B_WIDTH;
   localparam int X_WIDTH = 2 * B_WIDTH + A_WIDTH;
   logic [A_WIDTH-1:0] a_r, a2;
   logic [B_WIDTH-1:0] b_r, d_r, b2, d2, pre;
   logic [C_WIDTH-1:0] c_r, c2, c3;
   logic [7:0]         op_r;
   logic [4:0]         ctl2, ctl3;
   logic               cin_r, v_r, cin2, v2, cin3, v3;
   logic [M_WIDTH-1:0] m_c, m3;
   logic [X_WIDTH-1:0] cat3;
   logic [P_WIDTH-1:0] p_q, xs, zs, p_nxt;
   logic [P_WIDTH:0]   xc, sum;
   logic               co_q, upd, unused_op;
   // stage 1: capture operands, opmode, carry-in and valid
   always_ff @(posedge clk or posedge RST)
      if (RST) begin
         a_r <= '0;
         b_r <= '0;
         d_r <= '0;
         c_r <= '0;
         op_r <= '0;
         cin_r <= 1'b0;
         v_r <= 1'b0;
      end else if (CE) begin
         a_r <= A;
         b_r <= B;
         d_r <= D;
         c_r <= C;
         op_r <= OPMODE;
         cin_r <= CARRYIN;
         v_r <= in_valid;
      end
   assign unused_op = op_r[5];
   assign pre = op_r[4] ? (op_r[6] ? d_r - b_r : d_r + b_r) : b_r;
   // stage 2: pre-adder result plus the control bits the post-adder still needs
   always_ff @(posedge clk or posedge RST)
      if (RST) begin
         a2 <= '0;
         b2 <= '0;
         d2 <= '0;
         c2 <= '0;
         ctl2 <= '0;
         cin2 <= 1'b0;
         v2 <= 1'b0;
      end else if (CE) begin
         a2 <= a_r;
         b2 <= pre;
         d2 <= d_r;
         c2 <= c_r;
         ctl2 <= {op_r[7], op_r[3:0]};
         cin2 <= cin_r;
         v2 <= v_r;
      end
   assign m_c = M_WIDTH'(a2) * M_WIDTH'(b2);
   if (MREG != 0) begin : g_mreg
      // stage 3: registered product, concatenation and delayed controls
      always_ff @(posedge clk or posedge RST)
         if (RST) begin
            m3 <= '0;
            cat3 <= '0;
            c3 <= '0;
            ctl3 <= '0;
            cin3 <= 1'b0;
            v3 <= 1'b0;
         end else if (CE) begin
            m3 <= m_c;
            cat3 <= {d2, a2, b2};
            c3 <= c2;
            ctl3 <= ctl2;
            cin3 <= cin2;
            v3 <= v2;
         end
   end else begin : g_mcomb
      assign m3 = m_c;
      assign cat3 = {d2, a2, b2};
      assign c3 = c2;
      assign ctl3 = ctl2;
      assign cin3 = cin2;
      assign v3 = v2;
   end
   // post-adder: X/Z muxes and a P_WIDTH+1 bit add or subtract so the top bit is carry/borrow
   always_comb begin
      xs = ctl3[1:0] == 2'd0 ? '0 : ctl3[1:0] == 2'd1 ? P_WIDTH'(m3) : ctl3[1:0] == 2'd2 ? p_q : P_WIDTH'(cat3);
      zs = ctl3[3:2] == 2'd0 ? '0 : ctl3[3:2] == 2'd1 ? PCIN : ctl3[3:2] == 2'd2 ? p_q : P_WIDTH'(c3);
      xc = {1'b0, xs} + (P_WIDTH+1)'(cin3);
      sum = ctl3[4] ? {1'b0, zs} - xc : {1'b0, zs} + xc;
   end
`ifdef DSP_SAT_EN
   assign p_nxt = sum[P_WIDTH] ? (ctl3[4] ? '0 : '1) : sum[P_WIDTH-1:0];
`else
   assign p_nxt = sum[P_WIDTH-1:0];
`endif
   assign upd = CE & v3;
   // stage 4: P and carry update only on a valid, enabled edge; out_valid pulses per update
   always_ff @(posedge clk or posedge RST)
      if (RST) begin
         p_q <= '0;
         co_q <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= upd;
         if (upd) begin
            p_q <= p_nxt;
            co_q <= sum[P_WIDTH];
         end
      end
   if (ACC_LEN > 0) begin : g_acc
      localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
      logic [CW-1:0] cnt;
      logic          at_end, last_q;
      assign at_end = cnt == CW'(ACC_LEN - 1);
      // window counter: flag the update that closes the window, then wrap
      always_ff @(posedge clk or posedge RST)
         if (RST) begin
            cnt <= '0;
            last_q <= 1'b0;
         end else begin
            last_q <= upd & at_end;
            if (upd)
               cnt <= at_end ? '0 : cnt + 1'b1;
         end
      assign out_last = last_q;
   end else begin : g_noacc
      assign out_last = 1'b0;
   end
   assign P = p_q;
   assign PCOUT = p_q;
   assign BCOUT = b2;
   assign CARRYOUT = co_q;
endmodule

// File: tb/tb_dsp_mac_slice.sv
// tb_dsp_mac_slice: vector table, directed stall/reset/accumulate sequences and random traffic against a queue-based model
module tb_dsp_mac_slice;
`ifdef DSP_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic        clk = 1'b0, RST = 1'b1, CE = 1'b1, in_valid = 1'b0, CARRYIN = 1'b0;
   logic [17:0] A = '0, B = '0, D = '0;
   logic [47:0] C = '0, PCIN = '0;
   logic [7:0]  OPMODE = '0;
   logic [47:0] p0, pc0, p1, pc1;
   logic [17:0] bc0, bc1;
   logic        co0, co1, ov0, ov1, ol0, ol1;
   int          total = 0, bad = 0;
   bit          chk_en = 1'b0;
   always #5 clk = ~clk;
   dsp_mac_slice #(.MREG(1), .ACC_LEN(4)) dut0 (
      .clk(clk), .RST(RST), .CE(CE), .in_valid(in_valid), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
      .CARRYIN(CARRYIN), .OPMODE(OPMODE), .P(p0), .PCOUT(pc0), .BCOUT(bc0), .CARRYOUT(co0),
      .out_valid(ov0), .out_last(ol0));
   dsp_mac_slice #(.MREG(0), .ACC_LEN(0)) dut1 (
      .clk(clk), .RST(RST), .CE(CE), .in_valid(in_valid), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN),
      .CARRYIN(CARRYIN), .OPMODE(OPMODE), .P(p1), .PCOUT(pc1), .BCOUT(bc1), .CARRYOUT(co1),
      .out_valid(ov1), .out_last(ol1));

   typedef struct {
      logic [17:0] a, b, d;
      logic [47:0] c;
      logic [7:0]  op;
      logic        cin;
      int          age;
   } smp_t;
   smp_t        q[$];
   smp_t        s1;
   logic [47:0] mp[2];
   logic        mco[2], mov[2], mol[2];
   logic [17:0] mbc;
   int          mcnt;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   function automatic logic [17:0] pre(input smp_t s);
      return s.op[4] ? (s.op[6] ? s.d - s.b : s.d + s.b) : s.b;
   endfunction

   task automatic mreset();
      q.delete();
      s1 = '{default: '0};
      mp[0] = '0; mp[1] = '0;
      mco[0] = 0; mco[1] = 0; mov[0] = 0; mov[1] = 0; mol[0] = 0; mol[1] = 0;
      mbc = '0;
      mcnt = 0;
   endtask

   task automatic issue(input int k, input smp_t s);
      logic [17:0] bb;
      logic [53:0] cat;
      logic [47:0] x, z;
      logic [48:0] sum;
      bb = pre(s);
      cat = {s.d, s.a, bb};
      case (s.op[1:0])
         2'd0: x = '0;
         2'd1: x = 48'(s.a) * 48'(bb);
         2'd2: x = mp[k];
         default: x = cat[47:0];
      endcase
      case (s.op[3:2])
         2'd0: z = '0;
         2'd1: z = PCIN;
         2'd2: z = mp[k];
         default: z = s.c;
      endcase
      sum = s.op[7] ? {1'b0, z} - {1'b0, x} - 49'(s.cin) : {1'b0, z} + {1'b0, x} + 49'(s.cin);
      mco[k] = sum[48];
      mp[k] = (SAT && sum[48]) ? (s.op[7] ? 48'h0 : {48{1'b1}}) : sum[47:0];
      mov[k] = 1'b1;
      if (k == 0) begin
         mol[0] = (mcnt == 3);
         mcnt = (mcnt + 1) % 4;
      end
   endtask

   // model: a sample issues after 3 (MREG=0) or 4 (MREG=1) enabled edges, counting its capture edge
   always @(posedge clk)
      if (!RST) begin
         mov[0] = 0; mov[1] = 0; mol[0] = 0; mol[1] = 0;
         if (CE) begin
            mbc = pre(s1);
            foreach (q[i]) q[i].age++;
            foreach (q[i]) begin
               if (q[i].age == 2) issue(1, q[i]);
               if (q[i].age == 3) issue(0, q[i]);
            end
            while (q.size() > 0 && q[0].age == 3) void'(q.pop_front());
            s1 = '{A, B, D, C, OPMODE, CARRYIN, 0};
            if (in_valid) q.push_back(s1);
         end
      end

   always @(negedge clk)
      if (chk_en) begin
         chk("p0", p0, mp[0]); chk("pcout0", pc0, mp[0]); chk("co0", co0, mco[0]);
         chk("ov0", ov0, mov[0]); chk("ol0", ol0, mol[0]); chk("bcout0", bc0, mbc);
         chk("p1", p1, mp[1]); chk("pcout1", pc1, mp[1]); chk("co1", co1, mco[1]);
         chk("ov1", ov1, mov[1]); chk("ol1", ol1, mol[1]); chk("bcout1", bc1, mbc);
      end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      mreset();
      CE = 1'b1;
      in_valid = 1'b0;
      repeat (4) cyc();
      RST = 1'b0;
   endtask

   logic [47:0] gp0[$], gp1[$];
   logic        gl0[$];
   int          gc0[$], gc1[$];

   task automatic grab(input int ncyc, input int drop, input int st0, input int st1, input logic [17:0] a_next);
      bit          was_ce;
      logic [47:0] prev;
      gp0.delete(); gp1.delete(); gl0.delete(); gc0.delete(); gc1.delete();
      for (int c = 1; c <= ncyc; c++) begin
         was_ce = CE;
         prev = p0;
         cyc();
         if (!was_ce) begin
            chk("stall_hold_p0", p0, prev);
            chk("stall_ov0", ov0, 0);
         end
         if (ov0) begin gp0.push_back(p0); gl0.push_back(ol0); gc0.push_back(c); end
         if (ov1) begin gp1.push_back(p1); gc1.push_back(c); end
         if (c == 1) A = a_next;
         if (c == drop) in_valid = 1'b0;
         CE = !(c >= st0 && c < st1);
      end
   endtask

   typedef struct {
      logic [17:0] a, b, d;
      logic [47:0] c, pcin;
      logic        cin;
      logic [7:0]  op;
      logic [47:0] p;
      logic        co;
      logic [17:0] bc;
   } vec_t;
   vec_t tv[10];

   initial begin
      int n;
      tv[0] = '{3, 7, 5, 48'h0, 48'd6, 1'b0, 8'h15, 48'd42, 1'b0, 18'd12};
      tv[1] = '{3, 7, 5, 48'h0, 48'd6, 1'b1, 8'h15, 48'd43, 1'b0, 18'd12};
      tv[2] = '{3, 7, 5, 48'h0, 48'd6, 1'b0, 8'h95, SAT ? 48'h0 : 48'hFFFF_FFFF_FFE2, 1'b1, 18'd12};
      tv[3] = '{3, 7, 5, 48'h0, 48'd6, 1'b1, 8'h95, SAT ? 48'h0 : 48'hFFFF_FFFF_FFE1, 1'b1, 18'd12};
      tv[4] = '{3, 7, 5, 48'h0, 48'd6, 1'b0, 8'h55, 48'h0000_000C_0000, 1'b0, 18'h3FFFE};
      tv[5] = '{3, 7, 5, 48'h0, 48'd6, 1'b0, 8'h03, 48'h0050_000C_0007, 1'b0, 18'd7};
      tv[6] = '{3, 7, 5, 48'h1234_5678_9ABC, 48'd6, 1'b1, 8'h0C, 48'h1234_5678_9ABD, 1'b0, 18'd7};
      tv[7] = '{1, 1, 0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 8'h2D, SAT ? 48'hFFFF_FFFF_FFFF : 48'h0, 1'b1, 18'd1};
      tv[8] = '{3, 7, 5, 48'h0, 48'd0, 1'b1, 8'h80, SAT ? 48'h0 : 48'hFFFF_FFFF_FFFF, 1'b1, 18'd7};
      tv[9] = '{18'h3FFFF, 18'h3FFFF, 5, 48'h0, 48'd0, 1'b0, 8'h01, 48'h000F_FFF8_0001, 1'b0, 18'h3FFFF};
      cyc();
      do_reset();
      chk_en = 1'b1;
      chk("rst_p0", p0, 0);
      chk("rst_ov0", ov0, 0);
      for (int i = 0; i < 10; i++) begin
         A = tv[i].a; B = tv[i].b; D = tv[i].d; C = tv[i].c; PCIN = tv[i].pcin;
         CARRYIN = tv[i].cin; OPMODE = tv[i].op; in_valid = 1'b1;
         cyc();
         in_valid = 1'b0;
         n = 1;
         while (!ov0 && n < 10) begin cyc(); n++; end
         chk($sformatf("vec%0d_latency", i), n, 4);
         chk($sformatf("vec%0d_p", i), p0, tv[i].p);
         chk($sformatf("vec%0d_carry", i), co0, tv[i].co);
         chk($sformatf("vec%0d_bcout", i), bc0, tv[i].bc);
         repeat (2) cyc();
      end
      // accumulate window of 4 then restart
      do_reset();
      OPMODE = 8'h09; A = 2; B = 3; D = 0; C = 0; PCIN = 0; CARRYIN = 0; in_valid = 1'b1;
      grab(12, 5, 0, 0, 18'd2);
      chk("acc_n0", gp0.size(), 5);
      chk("acc_n1", gp1.size(), 5);
      for (int i = 0; i < 5 && i < gp0.size(); i++) begin
         chk($sformatf("acc_p%0d", i), gp0[i], 48'(6 * (i + 1)));
         chk($sformatf("acc_last%0d", i), gl0[i], i == 3);
         chk($sformatf("acc_cyc%0d", i), gc0[i], 4 + i);
      end
      for (int i = 0; i < 5 && i < gc1.size(); i++) chk($sformatf("acc_m0_cyc%0d", i), gc1[i], 3 + i);
      // three-cycle stall with two samples in flight
      do_reset();
      A = 2; in_valid = 1'b1;
      grab(14, 2, 2, 5, 18'd5);
      chk("stall_n0", gp0.size(), 2);
      chk("stall_n1", gp1.size(), 2);
      if (gp0.size() == 2) begin
         chk("stall_p0a", gp0[0], 6); chk("stall_p0b", gp0[1], 21);
         chk("stall_c0a", gc0[0], 7); chk("stall_c0b", gc0[1], 8);
      end
      if (gp1.size() == 2) begin
         chk("stall_p1a", gp1[0], 6); chk("stall_p1b", gp1[1], 21);
         chk("stall_c1a", gc1[0], 6); chk("stall_c1b", gc1[1], 7);
      end
      // asynchronous reset mid-accumulation, then window restarts from zero
      do_reset();
      A = 2; in_valid = 1'b1;
      repeat (6) cyc();
      chk("pre_rst_p0", p0, 18);
      #2;
      RST = 1'b1;
      mreset();
      #1;
      chk("arst_p0", p0, 0); chk("arst_co0", co0, 0); chk("arst_ov0", ov0, 0);
      chk("arst_ol0", ol0, 0); chk("arst_bc0", bc0, 0); chk("arst_p1", p1, 0);
      cyc();
      RST = 1'b0;
      grab(10, 4, 0, 0, 18'd2);
      chk("rst_restart_n", gp0.size(), 4);
      if (gp0.size() == 4) begin
         chk("rst_first_cyc", gc0[0], 4);
         chk("rst_last_p", gp0[3], 24);
         chk("rst_last_flag", gl0[3], 1);
         chk("rst_early_flag", gl0[2], 0);
      end
      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
         C = 48'({$urandom, $urandom}); PCIN = 48'({$urandom, $urandom});
         CARRYIN = 1'($urandom); OPMODE = 8'($urandom) & 8'hDF;
         in_valid = $urandom_range(0, 3) != 0;
         CE = $urandom_range(0, 5) != 0;
         cyc();
      end
      CE = 1'b1; in_valid = 1'b0;
      repeat (6) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
